sound_scheduler: RTL and testbench

SOUND_SCHEDULER -- requirements
Module: sound_scheduler

---
 rtl/sound_scheduler_pkg.sv | 9 +
 rtl/sound_scheduler_priority_encoder.sv | 24 ++
 rtl/sound_scheduler.sv | 105 ++++++++++
 tb/tb_sound_scheduler.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sound_scheduler_pkg.sv
// Shared audio-sample definitions used by the event-to-sample scheduler.
// The sample-bank select width lives here so both sides of the bank interface agree.
package sound_scheduler_pkg;

   localparam int AUDIO_SAMPLE_BITS = 2;

   typedef logic [AUDIO_SAMPLE_BITS-1:0] sample_idx_t;

endpackage

// File: rtl/sound_scheduler_priority_encoder.sv
// Highest-set-bit encoder over the pending event flags; idx is meaningful only when vld is high.
// Purely combinational (zero latency); no flow control.
module priority_encoder #(
   parameter int NUM_EVENTS = 4,
   parameter int IDX_BITS   = $clog2(NUM_EVENTS)
) (
   input  logic [NUM_EVENTS-1:0] req,
   output logic [IDX_BITS-1:0]   idx,
   output logic                  vld
);

   always_comb begin
      idx = '0;
      vld = 1'b0;
      // Ascending scan: the last hit is the highest index, which wins.
      for (int i = 0; i < NUM_EVENTS; i++) begin
         if (req[i]) begin
            idx = IDX_BITS'(i);
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sound_scheduler.sv
// Turns game event pulses into SELECT/TRIGGER for the sample bank, with priority preemption and coalescing.
// Trigger two cycles after a request in IDLE; requests never stall, repeats while pending pulse OVERFLOW.
module sound_scheduler
   import sound_scheduler_pkg::*;
#(
   parameter int SAMPLE_BITS = AUDIO_SAMPLE_BITS,
   parameter int NUM_EVENTS  = 4,
   parameter int PLAY_CYCLES = 2000000
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [NUM_EVENTS-1:0]  EVENT_REQ,
   input  logic                   MUTE,
   output logic [SAMPLE_BITS-1:0] AUDIO_SELECT,
   output logic                   AUDIO_TRIGGER,
   output logic                   BUSY,
   output logic                   OVERFLOW
);

   typedef enum logic [1:0] {IDLE, FIRE, PLAY} state_t;

   localparam int               CNT_W    = $clog2(PLAY_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PLAY_CYCLES - 2);

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [NUM_EVENTS-1:0]  pending, pending_nxt, clr;
   logic [SAMPLE_BITS-1:0] sel_nxt;
   logic [SAMPLE_BITS-1:0] pe_idx;
   logic                   pe_vld;
   logic                   overflow_nxt;

   priority_encoder #(
      .NUM_EVENTS (NUM_EVENTS),
      .IDX_BITS   (SAMPLE_BITS)
   ) u_prio (
      .req (pending),
      .idx (pe_idx),
      .vld (pe_vld)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sel_nxt   = AUDIO_SELECT;
      clr       = '0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (pe_vld && !MUTE) begin
               clr[pe_idx] = 1'b1;
               sel_nxt     = pe_idx;
               state_nxt   = FIRE;
            end
         end
         FIRE: begin
            cnt_nxt   = CNT_LOAD;
            state_nxt = PLAY;
         end
         PLAY: begin
            // Only a strictly higher sample may cut the current one short.
            if (pe_vld && !MUTE && (pe_idx > AUDIO_SELECT)) begin
               clr[pe_idx] = 1'b1;
               sel_nxt     = pe_idx;
               cnt_nxt     = '0;
               state_nxt   = FIRE;
            end else if (cnt == '0) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // A request landing on the flag being served re-arms it rather than being lost.
   always_comb begin
      pending_nxt  = MUTE ? '0 : ((pending & ~clr) | EVENT_REQ);
      overflow_nxt = !MUTE && (|(EVENT_REQ & pending & ~clr));
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= IDLE;
         cnt          <= '0;
         pending      <= '0;
         AUDIO_SELECT <= '0;
         OVERFLOW     <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         pending      <= pending_nxt;
         AUDIO_SELECT <= sel_nxt;
         OVERFLOW     <= overflow_nxt;
      end
   end

   assign AUDIO_TRIGGER = (state == FIRE);
   assign BUSY          = (state != IDLE);

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed-vector bench for sound_scheduler with an 8-cycle playback hold.
module tb_sound_scheduler;

   localparam int SB = 2;
   localparam int NE = 4;
   localparam int PC = 8;

   logic          CLK = 1'b0;
   logic          RESET;
   logic [NE-1:0] EVENT_REQ;
   logic          MUTE;
   logic [SB-1:0] AUDIO_SELECT;
   logic          AUDIO_TRIGGER;
   logic          BUSY;
   logic          OVERFLOW;

   int            total = 0;
   int            bad   = 0;
   int            trig_cnt;
   int            ovf_cnt;
   logic [SB-1:0] last_trig_sel;

   always #5 CLK = ~CLK;

   sound_scheduler #(
      .SAMPLE_BITS (SB),
      .NUM_EVENTS  (NE),
      .PLAY_CYCLES (PC)
   ) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .EVENT_REQ     (EVENT_REQ),
      .MUTE          (MUTE),
      .AUDIO_SELECT  (AUDIO_SELECT),
      .AUDIO_TRIGGER (AUDIO_TRIGGER),
      .BUSY          (BUSY),
      .OVERFLOW      (OVERFLOW)
   );

   typedef struct {
      logic [NE-1:0] req;
      logic          mute;
      logic          rst;
      logic [SB-1:0] sel;
      logic          trig;
      logic          busy;
      logic          ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [NE-1:0] r, input logic m, input logic rs,
                               input logic [SB-1:0] s, input logic t, input logic b,
                               input logic o);
      vec_t v;
      v.req = r; v.mute = m; v.rst = rs; v.sel = s; v.trig = t; v.busy = b; v.ovf = o;
      return v;
   endfunction

   // Drive one cycle of inputs, then sample outputs just after the rising edge.
   task automatic step(input logic [NE-1:0] req, input logic mute, input logic rst);
      EVENT_REQ = req;
      MUTE      = mute;
      RESET     = rst;
      @(posedge CLK);
      #1;
      if (AUDIO_TRIGGER === 1'b1) begin
         trig_cnt++;
         last_trig_sel = AUDIO_SELECT;
      end
      if (OVERFLOW === 1'b1) ovf_cnt++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   initial begin
      EVENT_REQ     = '0;
      MUTE          = 1'b0;
      RESET         = 1'b1;
      trig_cnt      = 0;
      ovf_cnt       = 0;
      last_trig_sel = '0;

      // Reset state, single request (sample 1), then simultaneous 2+0.
      vecs.push_back(mk(4'b0000, 0, 1, 2'd0, 0, 0, 0));
      vecs.push_back(mk(4'b0000, 0, 0, 2'd0, 0, 0, 0));
      vecs.push_back(mk(4'b0010, 0, 0, 2'd0, 0, 0, 0));
      vecs.push_back(mk(4'b0000, 0, 0, 2'd1, 1, 1, 0));
      for (int i = 0; i < PC - 1; i++) vecs.push_back(mk(4'b0000, 0, 0, 2'd1, 0, 1, 0));
      vecs.push_back(mk(4'b0000, 0, 0, 2'd1, 0, 0, 0));
      vecs.push_back(mk(4'b0101, 0, 0, 2'd1, 0, 0, 0));
      vecs.push_back(mk(4'b0000, 0, 0, 2'd2, 1, 1, 0));
      for (int i = 0; i < PC - 1; i++) vecs.push_back(mk(4'b0000, 0, 0, 2'd2, 0, 1, 0));
      vecs.push_back(mk(4'b0000, 0, 0, 2'd2, 0, 0, 0));
      vecs.push_back(mk(4'b0000, 0, 0, 2'd0, 1, 1, 0));
      for (int i = 0; i < PC - 1; i++) vecs.push_back(mk(4'b0000, 0, 0, 2'd0, 0, 1, 0));
      vecs.push_back(mk(4'b0000, 0, 0, 2'd0, 0, 0, 0));

      foreach (vecs[i]) begin
         step(vecs[i].req, vecs[i].mute, vecs[i].rst);
         check($sformatf("vec%0d{sel,trig,busy,ovf}", i),
               {27'd0, AUDIO_SELECT, AUDIO_TRIGGER, BUSY, OVERFLOW},
               {27'd0, vecs[i].sel, vecs[i].trig, vecs[i].busy, vecs[i].ovf});
      end

      // Preemption: sample 3 requested in the third PLAY cycle of sample 1.
      step('0, 0, 1);
      step(4'b0010, 0, 0);
      step('0, 0, 0);
      check("preempt_first", {30'd0, AUDIO_TRIGGER, BUSY}, 32'd3);
      step('0, 0, 0);
      step('0, 0, 0);
      step(4'b1000, 0, 0);
      check("preempt_req_cycle", {29'd0, AUDIO_SELECT, AUDIO_TRIGGER}, {29'd0, 2'd1, 1'b0});
      step('0, 0, 0);
      check("preempt_trig", {29'd0, AUDIO_SELECT, AUDIO_TRIGGER}, {29'd0, 2'd3, 1'b1});
      trig_cnt = 0;
      run(30);
      check("preempt_no_retrigger", trig_cnt, 0);
      check("preempt_sel_held", AUDIO_SELECT, 2'd3);

      // Coalescing: sample 0 requested twice behind a playing sample 2.
      step('0, 0, 1);
      step(4'b0100, 0, 0);
      step('0, 0, 0);
      step('0, 0, 0);
      ovf_cnt  = 0;
      trig_cnt = 0;
      step(4'b0001, 0, 0);
      check("ovf_first_req", OVERFLOW, 1'b0);
      step(4'b0001, 0, 0);
      check("ovf_pulse", OVERFLOW, 1'b1);
      step('0, 0, 0);
      check("ovf_one_cycle", OVERFLOW, 1'b0);
      run(30);
      check("ovf_single_trigger", trig_cnt, 1);
      check("ovf_trigger_sel", last_trig_sel, 2'd0);
      check("ovf_pulse_count", ovf_cnt, 1);

      // Mute during PLAY discards requests but playback runs to completion.
      step('0, 0, 1);
      step(4'b0010, 0, 0);
      step('0, 0, 0);
      step('0, 0, 0);
      trig_cnt = 0;
      step(4'b0110, 1, 0);
      step(4'b0110, 1, 0);
      step('0, 1, 0);
      step('0, 0, 0);
      step('0, 0, 0);
      step('0, 0, 0);
      check("mute_busy_last", BUSY, 1'b1);
      step('0, 0, 0);
      check("mute_busy_fall", BUSY, 1'b0);
      run(20);
      check("mute_no_trigger", trig_cnt, 0);

      // Reset in PLAY with a pending request; a same-cycle request is lost.
      step('0, 0, 1);
      step(4'b0100, 0, 0);
      step('0, 0, 0);
      step('0, 0, 0);
      step(4'b0001, 0, 0);
      step(4'b1000, 0, 1);
      check("rst_outputs", {28'd0, AUDIO_SELECT, AUDIO_TRIGGER, BUSY}, 32'd0);
      trig_cnt = 0;
      run(20);
      check("rst_no_trigger", trig_cnt, 0);
      check("rst_idle", BUSY, 1'b0);

      // Request on the very edge its flag is served re-arms it without overflow.
      step('0, 0, 1);
      step(4'b0010, 0, 0);
      ovf_cnt = 0;
      step(4'b0010, 0, 0);
      check("rearm_fire", {29'd0, AUDIO_SELECT, AUDIO_TRIGGER}, {29'd0, 2'd1, 1'b1});
      trig_cnt = 0;
      run(20);
      check("rearm_second_trigger", trig_cnt, 1);
      check("rearm_no_overflow", ovf_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
